pf_tile_fetch: RTL and testbench

- Playfield scanout stage. Reads tile codes from the playfield RAM's read port, then reads 2-plane pattern bytes from the character ROM.
- Serialises 8 pixels per tile into a 2-bit colour-index stream for the video mixer.
- Sits directly downstream of the dual-port playfield RAM (port B, registered read, 1-clk latency). The CPU owns port A.

---
 rtl/pf_tile_fetch.sv | 190 +++++++++++++++++++
 tb/tb_pf_tile_fetch.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pf_tile_fetch.sv
// rtl/pf_tile_fetch.sv - playfield tile fetch and 2-plane pixel serialiser
//
// Fetches one scanline of playfield tiles:
//   playfield RAM (tile code) -> character ROM (2-plane pattern) -> pending
//   buffer -> shifter -> 2-bit colour index, MSB pixel first.
//
// Ports:
//   clk, reset_n          core clock, asynchronous active-low reset
//   pix_ce, pix_active    a pixel is consumed when both are high
//   line_start, line_y    start-of-line pulse and scanline number
//   ram_addr, ram_q       playfield RAM port B (registered read, 1 clk)
//   rom_addr, rom_q       character ROM {plane1, plane0} (registered, 1 clk)
//   pix_color, pix_valid  registered pixel output, updated per consumed pixel
//   underrun              sticky, a tile was needed before it was fetched
module pf_tile_fetch #(
  parameter int COLS   = 32,
  parameter int RAM_AW = 10,
  parameter int ROM_AW = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_ce,
  input  logic              line_start,
  input  logic [7:0]        line_y,
  input  logic              pix_active,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [7:0]        ram_q,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_q,
  output logic [1:0]        pix_color,
  output logic              pix_valid,
  output logic              underrun
);

  // col must be able to hold COLS itself: it saturates there once the
  // last tile of the line has been stored.
  localparam int CW = $clog2(COLS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_ADDR,
    S_T_WAIT,
    S_G_ADDR,
    S_G_WAIT,
    S_STORE,
    S_HOLD
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [4:0]      row;
  logic [2:0]      fine;
  logic [CW-1:0]   col;
  logic [CW-1:0]   col_inc;
  logic            col_more;

  logic [15:0]     pending;
  logic            pending_valid;

  logic [7:0]      plane0;
  logic [7:0]      plane1;
  logic [2:0]      pix_cnt;

  logic            consume;

  assign consume  = pix_ce & pix_active;
  assign col_inc  = col + CW'(1);
  assign col_more = (col < CW'(COLS));

  // ---------------------------------------------------------------------
  // Fetch FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Fetch FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   state_next = S_IDLE;
      S_T_ADDR: state_next = S_T_WAIT;
      S_T_WAIT: state_next = S_G_ADDR;
      S_G_ADDR: state_next = S_G_WAIT;
      S_G_WAIT: state_next = S_STORE;
      // col is incremented on this same edge, so decide on the new value.
      S_STORE:  state_next = (col_inc < CW'(COLS)) ? S_HOLD : S_IDLE;
      // Only one tile is buffered ahead: the next fetch waits until the
      // shifter has taken the pending pattern.
      S_HOLD: begin
        if (!pending_valid && col_more) begin
          state_next = S_T_ADDR;
        end
      end
      default:  state_next = S_IDLE;
    endcase
    // A new line restarts the fetch from any state, including mid-fetch.
    if (line_start) begin
      state_next = S_T_ADDR;
    end
  end

  // ---------------------------------------------------------------------
  // Fetch datapath, pending buffer and pixel shifter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row           <= '0;
      fine          <= '0;
      col           <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      ram_addr      <= '0;
      rom_addr      <= '0;
      plane0        <= '0;
      plane1        <= '0;
      pix_cnt       <= '0;
      pix_color     <= '0;
      pix_valid     <= 1'b0;
      underrun      <= 1'b0;
    end else if (line_start) begin
      // line_start takes priority over everything else, including a pixel
      // consumed in the same clock, which is output as blank fill.
      row           <= line_y[7:3];
      fine          <= line_y[2:0];
      col           <= '0;
      pending_valid <= 1'b0;
      plane0        <= '0;
      plane1        <= '0;
      pix_cnt       <= '0;
      underrun      <= 1'b0;
      if (consume) begin
        pix_color <= '0;
        pix_valid <= 1'b0;
      end
    end else begin
      unique case (state)
        S_T_ADDR: ram_addr <= RAM_AW'(32'(row) * 32'(COLS) + 32'(col));
        S_G_ADDR: rom_addr <= ROM_AW'({ram_q, fine});
        S_STORE: begin
          pending <= rom_q;
          col     <= col_inc;
        end
        default: ;
      endcase

      if (consume) begin
        pix_cnt <= pix_cnt + 3'd1;
        if (pix_cnt == 3'd0) begin
          if (pending_valid) begin
            // Load and emit the MSB pixel in the same clock.
            pix_color     <= {pending[15], pending[7]};
            pix_valid     <= 1'b1;
            plane1        <= {pending[14:8], 1'b0};
            plane0        <= {pending[6:0], 1'b0};
            pending_valid <= 1'b0;
          end else begin
            // Nothing to load: the whole 8-pixel slot becomes blank fill.
            // Clearing the planes makes the following shifts output 0.
            pix_color <= '0;
            pix_valid <= 1'b0;
            plane1    <= '0;
            plane0    <= '0;
            if (col_more) begin
              underrun <= 1'b1;
            end
          end
        end else begin
          pix_color <= {plane1[7], plane0[7]};
          plane1    <= {plane1[6:0], 1'b0};
          plane0    <= {plane0[6:0], 1'b0};
        end
      end

      // STORE only happens while pending_valid is low (HOLD waits for the
      // drop), so this set never races the clear above.
      if (state == S_STORE) begin
        pending_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pf_tile_fetch.sv
// tb/tb_pf_tile_fetch.sv - self-checking bench for pf_tile_fetch
module tb_pf_tile_fetch;

  localparam int COLS   = 32;
  localparam int RAM_AW = 10;
  localparam int ROM_AW = 11;

  logic              clk;
  logic              reset_n;
  logic              pix_ce;
  logic              line_start;
  logic [7:0]        line_y;
  logic              pix_active;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram_q;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_q;
  logic [1:0]        pix_color;
  logic              pix_valid;
  logic              underrun;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ram_mem [0:(1<<RAM_AW)-1];
  logic [15:0] rom_mem [0:(1<<ROM_AW)-1];

  logic [1:0]  got_c [$];
  logic        got_v [$];

  pf_tile_fetch #(
    .COLS   (COLS),
    .RAM_AW (RAM_AW),
    .ROM_AW (ROM_AW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_ce     (pix_ce),
    .line_start (line_start),
    .line_y     (line_y),
    .pix_active (pix_active),
    .ram_addr   (ram_addr),
    .ram_q      (ram_q),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .pix_color  (pix_color),
    .pix_valid  (pix_valid),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memories, 1 clk latency.
  always @(posedge clk) begin
    ram_q <= ram_mem[ram_addr];
    rom_q <= rom_mem[rom_addr];
  end

  // Reference: pixel n of the line for scanline y, as {valid, color}.
  function automatic logic [2:0] model_pix(input logic [7:0] y, input int n);
    int          tile;
    int          bitpos;
    logic [7:0]  code;
    logic [15:0] pat;
    if (n >= COLS * 8) return 3'b000;
    tile   = n / 8;
    bitpos = 7 - (n % 8);
    code   = ram_mem[(int'(y[7:3]) * COLS + tile) % (1 << RAM_AW)];
    pat    = rom_mem[{code, y[2:0]}];
    return {1'b1, pat[8 + bitpos], pat[bitpos]};
  endfunction

  task automatic step(input logic ls, input logic ce, input logic act);
    line_start = ls;
    pix_ce     = ce;
    pix_active = act;
    @(posedge clk);
    @(negedge clk);
    line_start = 1'b0;
    pix_ce     = 1'b0;
    pix_active = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Consume n pixels, each preceded by gmin..gmax idle clocks.
  task automatic consume(input int n, input int gmin, input int gmax);
    for (int i = 0; i < n; i++) begin
      idle(int'($urandom_range(gmax, gmin)));
      step(1'b0, 1'b1, 1'b1);
      got_c.push_back(pix_color);
      got_v.push_back(pix_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(2);
    checks++; if (ram_addr !== '0)  begin errors++; $display("FAIL reset ram_addr got=%0h exp=0", ram_addr); end
    checks++; if (rom_addr !== '0)  begin errors++; $display("FAIL reset rom_addr got=%0h exp=0", rom_addr); end
    checks++; if (pix_color !== 2'd0) begin errors++; $display("FAIL reset pix_color got=%0d exp=0", pix_color); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset pix_valid got=%0b exp=0", pix_valid); end
    checks++; if (underrun !== 1'b0)  begin errors++; $display("FAIL reset underrun got=%0b exp=0", underrun); end
    reset_n = 1'b1;
    idle(2);
    // Reset arriving in G_WAIT of tile 0.
    line_y = 8'h55;
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    checks++; if (ram_addr !== 10'd320) begin errors++; $display("FAIL midfetch ram_addr got=%0d exp=320", ram_addr); end
    reset_n = 1'b0;
    #1;
    checks++; if (ram_addr !== '0 || rom_addr !== '0) begin errors++; $display("FAIL async_reset addr got=%0h/%0h exp=0/0", ram_addr, rom_addr); end
    checks++; if (pix_color !== 2'd0 || pix_valid !== 1'b0 || underrun !== 1'b0) begin
      errors++; $display("FAIL async_reset pix got=%0d/%0b/%0b exp=0/0/0", pix_color, pix_valid, underrun);
    end
    idle(2);
    reset_n = 1'b1;
    idle(10);
    checks++; if (ram_addr !== '0 || rom_addr !== '0) begin errors++; $display("FAIL idle_after_reset addr got=%0h/%0h exp=0/0", ram_addr, rom_addr); end
  endtask

  task automatic test_directed();
    logic [1:0] exp_c [8];
    exp_c = '{2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0};
    ram_mem[5*32+0]        = 8'h41;
    rom_mem[{8'h41, 3'd3}] = 16'hF0AA;
    got_c.delete(); got_v.delete();
    line_y = 8'h2B;
    step(1'b1, 1'b0, 1'b0);
    idle(4);
    checks++; if (ram_addr !== 10'h0A0) begin errors++; $display("FAIL directed ram_addr got=%0h exp=0a0", ram_addr); end
    checks++; if (rom_addr !== 11'h20B) begin errors++; $display("FAIL directed rom_addr got=%0h exp=20b", rom_addr); end
    idle(2);
    consume(8, 1, 1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_c[i] !== exp_c[i] || got_v[i] !== 1'b1) begin
        errors++; $display("FAIL directed pix%0d got c=%0d v=%0b exp c=%0d v=1", i, got_c[i], got_v[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_full_line();
    logic [7:0] y;
    logic [2:0] e;
    y = 8'($urandom);
    line_y = y;
    got_c.delete(); got_v.delete();
    step(1'b1, 1'b0, 1'b0);
    idle(5);
    consume(COLS * 8 + 1, 0, 0);
    for (int i = 0; i <= COLS * 8; i++) begin
      e = model_pix(y, i);
      checks++;
      if ({got_v[i], got_c[i]} !== e) begin
        errors++; $display("FAIL full_line pix%0d got v=%0b c=%0d exp v=%0b c=%0d", i, got_v[i], got_c[i], e[2], e[1:0]);
      end
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL full_line underrun got=%0b exp=0", underrun); end
  endtask

  task automatic test_underrun();
    logic [7:0] y;
    logic [2:0] e;
    got_c.delete(); got_v.delete();
    line_y = 8'($urandom);
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    consume(1, 0, 0);
    checks++; if (got_c[0] !== 2'd0 || got_v[0] !== 1'b0) begin
      errors++; $display("FAIL early_pix got c=%0d v=%0b exp c=0 v=0", got_c[0], got_v[0]);
    end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set got=%0b exp=1", underrun); end
    idle(3);
    y = 8'($urandom);
    line_y = y;
    got_c.delete(); got_v.delete();
    step(1'b1, 1'b0, 1'b0);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear got=%0b exp=0", underrun); end
    idle(5);
    consume(16, 0, 0);
    for (int i = 0; i < 16; i++) begin
      e = model_pix(y, i);
      checks++;
      if ({got_v[i], got_c[i]} !== e) begin
        errors++; $display("FAIL after_underrun pix%0d got v=%0b c=%0d exp v=%0b c=%0d", i, got_v[i], got_c[i], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_restart();
    logic [7:0] y1;
    logic [7:0] y2;
    logic [2:0] e;
    y1 = 8'($urandom);
    y2 = y1 ^ 8'h48;
    line_y = y1;
    got_c.delete(); got_v.delete();
    step(1'b1, 1'b0, 1'b0);
    idle(5);
    consume(100, 0, 0);
    for (int i = 0; i < 100; i++) begin
      e = model_pix(y1, i);
      checks++;
      if ({got_v[i], got_c[i]} !== e) begin
        errors++; $display("FAIL restart_a pix%0d got v=%0b c=%0d exp v=%0b c=%0d", i, got_v[i], got_c[i], e[2], e[1:0]);
      end
    end
    // line_start together with a consumed pixel: the pixel is blank.
    line_y = y2;
    step(1'b1, 1'b1, 1'b1);
    checks++; if (pix_color !== 2'd0 || pix_valid !== 1'b0) begin
      errors++; $display("FAIL restart_collide got c=%0d v=%0b exp c=0 v=0", pix_color, pix_valid);
    end
    got_c.delete(); got_v.delete();
    idle(5);
    consume(COLS * 8 + 1, 0, 0);
    for (int i = 0; i <= COLS * 8; i++) begin
      e = model_pix(y2, i);
      checks++;
      if ({got_v[i], got_c[i]} !== e) begin
        errors++; $display("FAIL restart_b pix%0d got v=%0b c=%0d exp v=%0b c=%0d", i, got_v[i], got_c[i], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_freeze();
    logic [7:0]        y;
    logic [2:0]        e;
    logic [RAM_AW-1:0] exp_ra;
    int                changes;
    y = 8'($urandom);
    line_y = y;
    got_c.delete(); got_v.delete();
    step(1'b1, 1'b0, 1'b0);
    idle(5);
    consume(27, 0, 0);
    // Tile 3 is in the shifter, so tile 4 is the one fetched/pending.
    exp_ra = RAM_AW'(int'(y[7:3]) * COLS + 4);
    e = model_pix(y, 26);
    changes = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, k[0], 1'b0);
      if ({pix_valid, pix_color} !== e || ram_addr !== exp_ra) changes++;
    end
    checks++; if (changes !== 0) begin errors++; $display("FAIL freeze_stable got=%0d changes exp=0", changes); end
    checks++; if (rom_addr !== {ram_mem[exp_ra], y[2:0]}) begin
      errors++; $display("FAIL freeze_rom_addr got=%0h exp=%0h", rom_addr, {ram_mem[exp_ra], y[2:0]});
    end
    consume(COLS * 8 - 27, 0, 0);
    for (int i = 0; i < COLS * 8; i++) begin
      e = model_pix(y, i);
      checks++;
      if ({got_v[i], got_c[i]} !== e) begin
        errors++; $display("FAIL freeze pix%0d got v=%0b c=%0d exp v=%0b c=%0d", i, got_v[i], got_c[i], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_random_gaps();
    logic [7:0] y;
    logic [2:0] e;
    y = 8'($urandom);
    line_y = y;
    got_c.delete(); got_v.delete();
    step(1'b1, 1'b0, 1'b0);
    idle(5 + int'($urandom_range(4, 0)));
    consume(COLS * 8, 0, 3);
    for (int i = 0; i < COLS * 8; i++) begin
      e = model_pix(y, i);
      checks++;
      if ({got_v[i], got_c[i]} !== e) begin
        errors++; $display("FAIL gaps pix%0d got v=%0b c=%0d exp v=%0b c=%0d", i, got_v[i], got_c[i], e[2], e[1:0]);
      end
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL gaps underrun got=%0b exp=0", underrun); end
  endtask

  initial begin
    reset_n    = 1'b0;
    pix_ce     = 1'b0;
    pix_active = 1'b0;
    line_start = 1'b0;
    line_y     = 8'h00;
    for (int i = 0; i < (1 << RAM_AW); i++) ram_mem[i] = 8'($urandom);
    for (int i = 0; i < (1 << ROM_AW); i++) rom_mem[i] = 16'($urandom);
    @(negedge clk);
    test_reset();
    test_directed();
    test_full_line();
    test_underrun();
    test_restart();
    test_freeze();
    test_random_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
